reg_skid_buffer: RTL and testbench
==================================

REG_SKID_BUFFER -- requirements
Module: reg_skid_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 4: width of in_data/out_data.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into out_data and skid register on reset.
REQ-003 Parameter COUNT_WIDTH, default 8: width of xfer_count.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_data  input  DATA_WIDTH  upstream payload.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_data  output  DATA_WIDTH  downstream payload, driven directly from a register.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 occupancy  output  2  number of words held: 0, 1 or 2.
REQ-013 xfer_count  output  COUNT_WIDTH  number of completed output transfers, modulo 2^COUNT_WIDTH.

Function
REQ-014 The block SHALL define in_xfer = in_valid & in_ready and out_xfer = out_valid & out_ready.
REQ-015 The block SHALL implement a three-state machine: EMPTY (occupancy 0), ONE (output register valid), TWO (output and skid registers valid).
REQ-016 in_ready SHALL be decoded from state only: 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready or in_valid to in_ready.
REQ-017 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-018 EMPTY: in_xfer -> ONE, out_data <= in_data; otherwise stay EMPTY.
REQ-019 ONE: in_xfer & !out_xfer -> TWO, skid <= in_data, out_data held.
REQ-020 ONE: in_xfer & out_xfer -> stay ONE, out_data <= in_data.
REQ-021 ONE: !in_xfer & out_xfer -> EMPTY; neither -> hold.
REQ-022 TWO: out_xfer -> ONE, out_data <= skid; otherwise hold.
REQ-023 Latency in_xfer to out_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 word/cycle when out_ready stays 1.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Words SHALL leave in acceptance order; no word dropped or duplicated.
REQ-026 xfer_count SHALL increment by 1 on each out_xfer cycle and wrap from 2^COUNT_WIDTH-1 to 0.
REQ-027 in_data and out_ready SHALL be ignored when their handshake qualifier is 0; in_valid with in_ready=0 SHALL have no effect.

Reset
REQ-028 While reset=1 at posedge clk: state <= EMPTY, out_data <= RESET_VALUE, skid <= RESET_VALUE, xfer_count <= 0.
REQ-029 While reset input is 1, in_ready SHALL be forced to 0 and no transfer SHALL be counted or accepted.
REQ-030 Reset asserted mid-operation (ONE or TWO) SHALL discard held words; out_valid=0 and occupancy=0 from the cycle after the reset edge.
REQ-031 First cycle after reset deasserts: in_ready=1, out_valid=0, occupancy=0, out_data=RESET_VALUE.

Verification
REQ-032 Reset then idle -> out_valid=0, in_ready=1, occupancy=0, out_data=0, xfer_count=0.
REQ-033 Stream 0x1..0xF with out_ready=1 every cycle -> out_data 0x1..0xF on consecutive cycles, 1-cycle latency, in_ready constantly 1, xfer_count=15.
REQ-034 out_ready=0, push 0x3 then 0x5 -> occupancy 2, in_ready=0, out_data=0x3 stable; raise out_ready -> 0x3 then 0x5 delivered, occupancy 2->1->0.
REQ-035 In ONE with out_data=0x7, in_valid=1 in_data=0x9 and out_ready=1 same cycle -> next cycle out_data=0x9, occupancy 1, xfer_count+1.
REQ-036 Fill to TWO (0xA, 0xB), assert reset one cycle -> out_valid=0, occupancy=0, out_data=0, xfer_count=0; no 0xA/0xB ever delivered.
REQ-037 COUNT_WIDTH=8, 256 out transfers from reset -> xfer_count=0; 257 -> xfer_count=1.

Source files
------------

// File: rtl/reg_skid_buffer.sv
// Two-entry registered skid buffer: out_data comes straight from a register and
// in_ready is decoded from state only, so neither side sees a combinational path.
module reg_skid_buffer #(
  parameter int                    DATA_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [DATA_WIDTH-1:0]  out_data_reg;
  logic [DATA_WIDTH-1:0]  skid_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   in_xfer;
  logic                   out_xfer;

  // reset gates in_ready so nothing is accepted while the block is being cleared
  assign in_ready   = (state_reg != TWO) & ~reset;
  assign out_valid  = (state_reg != EMPTY);
  assign out_data   = out_data_reg;
  assign xfer_count = count_reg;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_reg)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= EMPTY;
      out_data_reg <= RESET_VALUE;
      skid_reg     <= RESET_VALUE;
      count_reg    <= '0;
    end else begin
      if (out_xfer) begin
        count_reg <= count_reg + COUNT_WIDTH'(1);
      end
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_reg    <= ONE;
            out_data_reg <= in_data;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            state_reg <= TWO;
            skid_reg  <= in_data;
          end else if (in_xfer && out_xfer) begin
            out_data_reg <= in_data;
          end else if (out_xfer) begin
            state_reg <= EMPTY;
          end
        end
        TWO: begin
          // the skid word moves up; in_ready is low so no new word arrives here
          if (out_xfer) begin
            state_reg    <= ONE;
            out_data_reg <= skid_reg;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_skid_buffer.sv
// Bench for reg_skid_buffer: a queue model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_reg_skid_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready = 1'b0;
  logic [1:0] occupancy;
  logic [7:0] xfer_count;

  int checks = 0;
  int errors = 0;

  reg_skid_buffer #(
    .DATA_WIDTH (4),
    .RESET_VALUE(4'h0),
    .COUNT_WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // Model: the buffer is a FIFO of at most two words; out_data shows the head,
  // or the last head if the FIFO has drained since reset.
  logic [3:0] q[$];
  logic [3:0] m_shown = 4'h0;
  logic [7:0] m_count = 8'h0;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    bit ix, ox;
    if (reset) begin
      q.delete();
      m_shown = 4'h0;
      m_count = 8'h0;
      m_live  = 1'b1;
    end else begin
      ix = in_valid && (q.size() < 2);
      ox = out_ready && (q.size() > 0);
      if (ox) begin
        void'(q.pop_front());
        m_count = m_count + 8'd1;
      end
      if (ix) q.push_back(in_data);
      if (q.size() > 0) m_shown = q[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("m_in_ready", 32'(in_ready), 32'((q.size() < 2) && !reset));
      chk("m_occupancy", 32'(occupancy), 32'(q.size()));
      chk("m_out_data", 32'(out_data), 32'(m_shown));
      chk("m_xfer_count", 32'(xfer_count), 32'(m_count));
    end
  end

  task automatic step(input logic iv, input logic [3:0] id, input logic ordy, input logic rst);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    reset     = rst;
    @(posedge clk);
    #1;
    $display("step rst=%0d iv=%0d id=%0h ordy=%0d -> ov=%0d od=%0h ir=%0d occ=%0d cnt=%0d",
             rst, iv, id, ordy, out_valid, out_data, in_ready, occupancy, xfer_count);
  endtask

  initial begin
    // reset then idle
    step(0, 4'h0, 0, 1);
    step(0, 4'h0, 0, 1);
    step(0, 4'h0, 0, 0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_occupancy", 32'(occupancy), 32'd0);
    chk("idle_out_data", 32'(out_data), 32'h0);
    chk("idle_xfer_count", 32'(xfer_count), 32'd0);

    // stream 1..F with out_ready high
    for (int i = 1; i <= 15; i++) begin
      logic [3:0] w;
      w = 4'(i);
      step(1, w, 1, 0);
      chk("stream_out_data", 32'(out_data), 32'(i));
      chk("stream_out_valid", 32'(out_valid), 32'd1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    step(0, 4'h0, 1, 0);
    chk("stream_count", 32'(xfer_count), 32'd15);
    chk("stream_drained", 32'(out_valid), 32'd0);

    // backpressure fills the skid register
    step(0, 4'h0, 0, 1);
    step(1, 4'h3, 0, 0);
    step(1, 4'h5, 0, 0);
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_data", 32'(out_data), 32'h3);
    step(1, 4'h6, 0, 0);
    chk("bp_stable", 32'(out_data), 32'h3);
    step(0, 4'h0, 1, 0);
    chk("bp_second", 32'(out_data), 32'h5);
    chk("bp_occ1", 32'(occupancy), 32'd1);
    step(0, 4'h0, 1, 0);
    chk("bp_occ0", 32'(occupancy), 32'd0);
    chk("bp_count", 32'(xfer_count), 32'd2);

    // simultaneous in and out while holding one word
    step(0, 4'h0, 0, 1);
    step(1, 4'h7, 0, 0);
    chk("pass_first", 32'(out_data), 32'h7);
    step(1, 4'h9, 1, 0);
    chk("pass_out_data", 32'(out_data), 32'h9);
    chk("pass_occ", 32'(occupancy), 32'd1);
    chk("pass_count", 32'(xfer_count), 32'd1);

    // reset while full discards both words
    step(0, 4'h0, 0, 1);
    step(1, 4'hA, 0, 0);
    step(1, 4'hB, 0, 0);
    chk("rst_full_occ", 32'(occupancy), 32'd2);
    step(0, 4'h0, 1, 1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_count", 32'(xfer_count), 32'd0);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    step(0, 4'h0, 1, 0);
    chk("rst_after_valid", 32'(out_valid), 32'd0);
    chk("rst_after_in_ready", 32'(in_ready), 32'd1);

    // counter wrap: 256 transfers then one more
    for (int i = 0; i < 256; i++) begin
      logic [3:0] w;
      w = 4'(i);
      step(1, w, 1, 0);
    end
    step(0, 4'h0, 1, 0);
    chk("wrap_256", 32'(xfer_count), 32'd0);
    step(1, 4'h1, 1, 0);
    step(0, 4'h0, 1, 0);
    chk("wrap_257", 32'(xfer_count), 32'd1);

    // randomized traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      logic iv, ordy, rst;
      logic [3:0] d;
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 3) != 0 ? $urandom_range(0, 1) : 0);
      rst  = ($urandom_range(0, 63) == 0);
      d    = 4'($urandom);
      step(iv, d, ordy, rst);
    end
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 1, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
